// File: rtl/ssrv_mem_slave_if.sv
// ssrv_mem_slave_if: fetch and data request/response bundle between ssrv_top and its memory
interface ssrv_mem_slave_if #(
  parameter int XLEN = 32,
  parameter int BUS_LEN = 4
);
  logic imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [BUS_LEN*XLEN-1:0] imem_rdata;
  logic imem_resp;
  logic dmem_req;
  logic dmem_cmd;
  logic [1:0] dmem_width;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic dmem_resp;
  logic dmem_err;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input imem_rdata, imem_resp, dmem_rdata, dmem_resp, dmem_err
  );
  modport slave (
    input imem_req, imem_addr, dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output imem_rdata, imem_resp, dmem_rdata, dmem_resp, dmem_err
  );
endinterface

// File: rtl/ssrv_mem_slave.sv
// ssrv_mem_slave: byte-addressed RAM serving ssrv_top fetch and data ports with fixed latencies
module ssrv_mem_slave #(
  parameter int XLEN = 32,
  parameter int BUS_LEN = 4,
  parameter int AW = 16,
  parameter int ILAT = 1,
  parameter int DLAT = 1
) (
  input logic clk,
  input logic rst,
  ssrv_mem_slave_if.slave bus
);
  localparam int IW = BUS_LEN * XLEN;
  localparam int NB = IW / 8;
  localparam int DW = XLEN + 1;
  logic [7:0] mem [2**AW];
  logic [AW-1:0] ia, wa;
  logic [1:0] lo;
  logic mis, wr, unused;
  logic [3:0] mask;
  logic [XLEN-1:0] word;
  logic [IW-1:0] fetch;
  logic [DW-1:0] dpay;
  logic [ILAT-1:0] ivld;
  logic [DLAT-1:0] dvld;
  logic [IW-1:0] idat [ILAT];
  logic [DW-1:0] ddat [DLAT];
  assign unused = ^{bus.imem_addr[XLEN-1:AW], bus.dmem_addr[XLEN-1:AW]};
  always_comb begin
    ia = bus.imem_addr[AW-1:0];
    wa = {bus.dmem_addr[AW-1:2], 2'b00};
    lo = bus.dmem_addr[1:0];
    fetch = '0;
    word = '0;
    for (int n = 0; n < NB; n++) fetch[8*n +: 8] = mem[ia + AW'(n)];
    for (int k = 0; k < 4; k++) word[8*k +: 8] = mem[wa + AW'(k)];
    mis = (bus.dmem_width == 2'b01 & lo[0]) | (bus.dmem_width[1] & lo != 2'b00);
    mask = bus.dmem_width[1] ? 4'hF : bus.dmem_width[0] ? 4'b0011 << lo : 4'b0001 << lo;
    wr = bus.dmem_req & bus.dmem_cmd & ~mis & ~rst;
    dpay = {mis, (bus.dmem_cmd | mis) ? '0 : word};
  end
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (wr && mask[k]) mem[wa + AW'(k)] <= bus.dmem_wdata[8*k +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      ivld <= '0;
      dvld <= '0;
      for (int i = 0; i < ILAT; i++) idat[i] <= '0;
      for (int i = 0; i < DLAT; i++) ddat[i] <= '0;
    end else begin
      ivld <= ILAT'({ivld, bus.imem_req});
      dvld <= DLAT'({dvld, bus.dmem_req});
      if (bus.imem_req) idat[0] <= fetch;
      if (bus.dmem_req) ddat[0] <= dpay;
      for (int i = 1; i < ILAT; i++) if (ivld[i-1]) idat[i] <= idat[i-1];
      for (int i = 1; i < DLAT; i++) if (dvld[i-1]) ddat[i] <= ddat[i-1];
    end
  assign bus.imem_resp = ivld[ILAT-1];
  assign bus.imem_rdata = idat[ILAT-1];
  assign bus.dmem_resp = dvld[DLAT-1];
  assign {bus.dmem_err, bus.dmem_rdata} = ddat[DLAT-1];
endmodule

// File: tb/tb_ssrv_mem_slave.sv
// tb_ssrv_mem_slave: directed scoreboard bench for two ssrv_mem_slave latency configurations
module tb_ssrv_mem_slave;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  int en = 0;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    int due;
    logic [127:0] d;
  } exp_t;
  exp_t iqa[$], iqb[$], dqa[$], dqb[$];
  logic [7:0] mm [2][65536];
  ssrv_mem_slave_if #(.XLEN(32), .BUS_LEN(4)) ifa();
  ssrv_mem_slave_if #(.XLEN(32), .BUS_LEN(4)) ifb();
  ssrv_mem_slave #(.XLEN(32), .BUS_LEN(4), .AW(16), .ILAT(1), .DLAT(2)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  ssrv_mem_slave #(.XLEN(32), .BUS_LEN(4), .AW(16), .ILAT(3), .DLAT(1)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  task automatic cmp(string tag, logic [127:0] got, logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] mfetch(int u, logic [31:0] a);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = mm[u][16'(a + 32'(n))];
    return r;
  endfunction
  task automatic fetch(int u, logic [31:0] a, logic usem = 1, logic [127:0] ex = '0);
    exp_t x;
    x.d = usem ? mfetch(u, a) : ex;
    x.due = en + (u == 0 ? 1 : 3);
    if (u == 0) begin
      ifa.imem_req = 1;
      ifa.imem_addr = a;
      if (!rst) iqa.push_back(x);
    end else begin
      ifb.imem_req = 1;
      ifb.imem_addr = a;
      if (!rst) iqb.push_back(x);
    end
  endtask
  task automatic dreq(int u, logic c, logic [1:0] w, logic [31:0] a, logic [31:0] wd,
                      logic usem = 1, logic [32:0] ex = '0);
    exp_t x;
    logic mis;
    logic [3:0] m;
    logic [31:0] r;
    logic [15:0] wa;
    mis = (w == 2'b01 && a[0]) || (w[1] && a[1:0] != 2'b00);
    m = w[1] ? 4'hF : w[0] ? 4'h3 << a[1:0] : 4'h1 << a[1:0];
    wa = {a[15:2], 2'b00};
    for (int k = 0; k < 4; k++) r[8*k +: 8] = mm[u][wa + 16'(k)];
    if (c || mis) r = '0;
    x.d = usem ? 128'({mis, r}) : 128'(ex);
    x.due = en + (u == 0 ? 2 : 1);
    if (!rst && c && !mis)
      for (int k = 0; k < 4; k++) if (m[k]) mm[u][wa + 16'(k)] = wd[8*k +: 8];
    if (u == 0) begin
      {ifa.dmem_req, ifa.dmem_cmd, ifa.dmem_width, ifa.dmem_addr, ifa.dmem_wdata} = {1'b1, c, w, a, wd};
      if (!rst) dqa.push_back(x);
    end else begin
      {ifb.dmem_req, ifb.dmem_cmd, ifb.dmem_width, ifb.dmem_addr, ifb.dmem_wdata} = {1'b1, c, w, a, wd};
      if (!rst) dqb.push_back(x);
    end
  endtask
  task automatic tick();
    exp_t x;
    logic e;
    @(posedge clk);
    en++;
    if (rst) begin
      iqa.delete();
      iqb.delete();
      dqa.delete();
      dqb.delete();
    end
    @(negedge clk);
    e = 0;
    if (iqa.size() > 0) e = (iqa[0].due == en);
    cmp("a.imem_resp", 128'(ifa.imem_resp), 128'(e));
    if (e) begin
      x = iqa.pop_front();
      cmp("a.imem_rdata", ifa.imem_rdata, x.d);
    end
    e = 0;
    if (iqb.size() > 0) e = (iqb[0].due == en);
    cmp("b.imem_resp", 128'(ifb.imem_resp), 128'(e));
    if (e) begin
      x = iqb.pop_front();
      cmp("b.imem_rdata", ifb.imem_rdata, x.d);
    end
    e = 0;
    if (dqa.size() > 0) e = (dqa[0].due == en);
    cmp("a.dmem_resp", 128'(ifa.dmem_resp), 128'(e));
    if (e) begin
      x = dqa.pop_front();
      cmp("a.dmem_err_rdata", 128'({ifa.dmem_err, ifa.dmem_rdata}), x.d);
    end
    e = 0;
    if (dqb.size() > 0) e = (dqb[0].due == en);
    cmp("b.dmem_resp", 128'(ifb.dmem_resp), 128'(e));
    if (e) begin
      x = dqb.pop_front();
      cmp("b.dmem_err_rdata", 128'({ifb.dmem_err, ifb.dmem_rdata}), x.d);
    end
    ifa.imem_req = 0;
    ifa.dmem_req = 0;
    ifb.imem_req = 0;
    ifb.dmem_req = 0;
  endtask
  initial begin
    {ifa.imem_req, ifa.imem_addr, ifa.dmem_req, ifa.dmem_cmd, ifa.dmem_width, ifa.dmem_addr, ifa.dmem_wdata} = '0;
    {ifb.imem_req, ifb.imem_addr, ifb.dmem_req, ifb.dmem_cmd, ifb.dmem_width, ifb.dmem_addr, ifb.dmem_wdata} = '0;
    fetch(0, 32'h100);
    tick();
    tick();
    tick();
    cmp("rst.a.imem_rdata", ifa.imem_rdata, '0);
    cmp("rst.a.dmem_err_rdata", 128'({ifa.dmem_err, ifa.dmem_rdata}), '0);
    cmp("rst.b.imem_rdata", ifb.imem_rdata, '0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      dreq(0, 1, 2'b10, 32'h100 + 32'(4*i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
      tick();
    end
    dreq(0, 1, 2'b10, 32'h0, 32'h08070605); tick();
    dreq(0, 1, 2'b10, 32'h4, 32'h0C0B0A09); tick();
    dreq(0, 1, 2'b10, 32'h8, 32'h100F0E0D); tick();
    dreq(0, 1, 2'b10, 32'hFFFC, 32'h04030201); tick();
    fetch(0, 32'h100, 0, 128'h0F0E0D0C0B0A09080706050403020100); tick();
    dreq(0, 1, 2'b10, 32'h40, 32'hDEADBEEF); tick();
    dreq(0, 0, 2'b10, 32'h40, 32'h0, 0, {1'b0, 32'hDEADBEEF}); tick();
    dreq(0, 1, 2'b10, 32'h80, 32'h11223344); tick();
    dreq(0, 1, 2'b00, 32'h81, 32'h0000AA00); tick();
    dreq(0, 0, 2'b10, 32'h80, 32'h0, 0, {1'b0, 32'h1122AA44}); tick();
    dreq(0, 1, 2'b01, 32'h82, 32'hBBBB0000); tick();
    dreq(0, 0, 2'b10, 32'h80, 32'h0, 0, {1'b0, 32'hBBBBAA44}); tick();
    dreq(0, 1, 2'b01, 32'h83, 32'hCCCCCCCC, 0, {1'b1, 32'h0}); tick();
    dreq(0, 0, 2'b10, 32'h80, 32'h0, 0, {1'b0, 32'hBBBBAA44}); tick();
    dreq(0, 1, 2'b10, 32'h42, 32'h0, 0, {1'b1, 32'h0}); tick();
    dreq(0, 0, 2'b01, 32'h81, 32'h0, 0, {1'b1, 32'h0}); tick();
    dreq(0, 0, 2'b00, 32'h43, 32'h0, 0, {1'b0, 32'hDEADBEEF}); tick();
    dreq(0, 0, 2'b11, 32'h80, 32'h0, 0, {1'b0, 32'hBBBBAA44}); tick();
    dreq(0, 1, 2'b11, 32'h84, 32'hCAFEF00D); tick();
    dreq(0, 0, 2'b10, 32'h84, 32'h0, 0, {1'b0, 32'hCAFEF00D}); tick();
    fetch(0, 32'hFFFC, 0, 128'h100F0E0D0C0B0A09_0807060504030201); tick();
    fetch(0, 32'h102); tick();
    fetch(0, 32'h100, 0, 128'h0F0E0D0C0B0A09080706050403020100);
    dreq(0, 1, 2'b10, 32'h100, 32'h12345678);
    tick();
    fetch(0, 32'h100); tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      dreq(1, 1, 2'b10, 32'h200 + 32'(4*i), 32'hA0A1A2A3 + 32'(i * 32'h04040404));
      tick();
    end
    fetch(1, 32'h200); tick();
    fetch(1, 32'h204); tick();
    tick();
    tick();
    fetch(1, 32'h200); tick();
    fetch(1, 32'h204); tick();
    rst = 1;
    fetch(1, 32'h208); tick();
    rst = 0;
    tick();
    tick();
    tick();
    cmp("post_rst.b.imem_rdata", ifb.imem_rdata, '0);
    cmp("post_rst.a.imem_rdata", ifa.imem_rdata, '0);
    cmp("post_rst.a.dmem_err_rdata", 128'({ifa.dmem_err, ifa.dmem_rdata}), '0);
    dreq(0, 0, 2'b10, 32'h40, 32'h0, 0, {1'b0, 32'hDEADBEEF}); tick();
    fetch(1, 32'h200); tick();
    for (int i = 0; i < 4; i++) tick();
    cmp("queues_drained", 128'(iqa.size() + iqb.size() + dqa.size() + dqb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
